// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, fetches over imem req/ack, presents the IR to the decoders.
// Optional perf counters (fetchCount/stallCount) are built when IFETCH_PERF_CNT_EN is defined.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] instWord,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] target26,
    output logic [31:0] instPc,
    output logic [31:0] instPcPlus4,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] stallCount
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pendingPc;
    logic        dropPending;
    logic [31:0] rdPc;

    assign rdPc     = {redirectPc[31:2], 2'b00};
    assign imemReq  = (state == REQ);
    assign imemAddr = pc;

    assign opcode      = instWord[31:26];
    assign rs          = instWord[25:21];
    assign rt          = instWord[20:16];
    assign rd          = instWord[15:11];
    assign shamt       = instWord[10:6];
    assign funct       = instWord[5:0];
    assign imm16       = instWord[15:0];
    assign target26    = instWord[25:0];
    assign instPcPlus4 = instPc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pendingPc   <= RESET_PC;
            dropPending <= 1'b0;
            instValid   <= 1'b0;
            instWord    <= '0;
            instPc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirectValid) pc <= rdPc;
                    state <= REQ;
                end
                REQ: begin
                    if (imemAck) begin
                        if (dropPending || redirectValid) begin
                            // Stale response: discard it and re-request at the newest target.
                            dropPending <= 1'b0;
                            pc          <= redirectValid ? rdPc : pendingPc;
                        end else begin
                            instWord  <= imemRdata;
                            instPc    <= pc;
                            pc        <= pc + 32'd4;
                            instValid <= 1'b1;
                            state     <= HOLD;
                        end
                    end else if (redirectValid) begin
                        // Address must stay stable while the request is outstanding.
                        dropPending <= 1'b1;
                        pendingPc   <= rdPc;
                    end
                end
                HOLD: begin
                    if (instReady || redirectValid) begin
                        instValid <= 1'b0;
                        state     <= REQ;
                    end
                    if (redirectValid) pc <= rdPc;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            if (instValid && instReady) fetchCount <= fetchCount + 32'd1;
            if (imemReq && !imemAck)    stallCount <= stallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: table-driven fetch vectors with a delivery scoreboard,
// plus hand sequences for redirects, PC wrap and mid-request reset.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        instValid;
    logic        instReady;
    logic [31:0] instWord;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] instPc, instPcPlus4;
    logic        redirectValid;
    logic [31:0] redirectPc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetchCount, stallCount;
    logic [31:0] expFetch, expStall;
`endif

    inst_fetch dut (
        .clk(clk), .rst(rst),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemRdata(imemRdata),
        .instValid(instValid), .instReady(instReady), .instWord(instWord),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .target26(target26), .instPc(instPc), .instPcPlus4(instPcPlus4),
        .redirectValid(redirectValid), .redirectPc(redirectPc)
`ifdef IFETCH_PERF_CNT_EN
        , .fetchCount(fetchCount), .stallCount(stallCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ackDly;
        int          rdyDly;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    int   nChecks = 0;
    int   nFail = 0;

`ifdef IFETCH_PERF_CNT_EN
    // Independent event counts for the perf counters.
    always @(posedge clk) begin
        if (rst) begin
            expFetch <= '0;
            expStall <= '0;
        end else begin
            if (instValid && instReady) expFetch <= expFetch + 32'd1;
            if (imemReq && !imemAck)    expStall <= expStall + 32'd1;
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic waitReq();
        int n = 0;
        while (!imemReq && n < 10) begin
            tick();
            n++;
        end
        chk("reqTimeout", {31'b0, imemReq}, 32'd1);
    endtask

    // Called in HOLD with instReady about to be driven high.
    task automatic deliver();
        exp_t e;
        if (sb.size() == 0) begin
            nChecks++;
            nFail++;
            $display("FAIL sbEmpty: got delivery, want none");
        end else begin
            e = sb.pop_front();
            chk("dlvValid", {31'b0, instValid}, 32'd1);
            chk("dlvWord", instWord, e.word);
            chk("dlvPc", instPc, e.pc);
            chk("dlvPcPlus4", instPcPlus4, e.pc + 32'd4);
            chk("dlvOpcode", {26'b0, opcode}, {26'b0, e.word[31:26]});
            chk("dlvRs", {27'b0, rs}, {27'b0, e.word[25:21]});
            chk("dlvRt", {27'b0, rt}, {27'b0, e.word[20:16]});
            chk("dlvRd", {27'b0, rd}, {27'b0, e.word[15:11]});
            chk("dlvShamt", {27'b0, shamt}, {27'b0, e.word[10:6]});
            chk("dlvFunct", {26'b0, funct}, {26'b0, e.word[5:0]});
            chk("dlvImm16", {16'b0, imm16}, {16'b0, e.word[15:0]});
            chk("dlvTarget", {6'b0, target26}, {6'b0, e.word[25:0]});
        end
    endtask

    task automatic ackWord(input logic [31:0] addr, input logic [31:0] word);
        imemAck   = 1'b1;
        imemRdata = word;
        sb.push_back('{addr, word});
        tick();
        imemAck   = 1'b0;
        imemRdata = $urandom;
    endtask

    task automatic doFetch(input logic [31:0] addr, input int ackDly, input int rdyDly,
                           input logic [31:0] word);
        waitReq();
        chk("fetchAddr", imemAddr, addr);
        for (int i = 0; i < ackDly; i++) begin
            chk("reqHeld", {31'b0, imemReq}, 32'd1);
            chk("addrHeld", imemAddr, addr);
            tick();
        end
        ackWord(addr, word);
        chk("validAfterAck", {31'b0, instValid}, 32'd1);
        for (int i = 0; i < rdyDly; i++) begin
            chk("holdValid", {31'b0, instValid}, 32'd1);
            chk("holdNoReq", {31'b0, imemReq}, 32'd0);
            chk("holdWord", instWord, word);
            chk("holdPc", instPc, addr);
            tick();
        end
        instReady = 1'b1;
        deliver();
        tick();
        instReady = 1'b0;
        chk("validDrop", {31'b0, instValid}, 32'd0);
        chk("reqAfterReady", {31'b0, imemReq}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_3000, 0, 0, 32'h8C22_0004};
        vecs[1] = '{32'h0000_3004, 0, 0, 32'h0043_2020};
        vecs[2] = '{32'h0000_3008, 0, 0, 32'hAC64_FFFC};
        vecs[3] = '{32'h0000_300C, 3, 0, 32'h0800_0C40};
        vecs[4] = '{32'h0000_3010, 0, 5, 32'h1085_0003};
        vecs[5] = '{32'h0000_3014, 1, 1, 32'h0000_4182};

        rst = 1'b1; imemAck = 1'b0; imemRdata = '0; instReady = 1'b0;
        redirectValid = 1'b0; redirectPc = '0;
        tick(); tick();
        chk("rstReq", {31'b0, imemReq}, 32'd0);
        chk("rstValid", {31'b0, instValid}, 32'd0);
        chk("rstWord", instWord, 32'd0);
        chk("rstPc", instPc, 32'd0);
        chk("rstAddr", imemAddr, 32'h0000_3000);
        rst = 1'b0;

        foreach (vecs[i]) doFetch(vecs[i].addr, vecs[i].ackDly, vecs[i].rdyDly, vecs[i].word);

        // Redirect while waiting for ack: address held, response dropped.
        waitReq();
        chk("rdReqAddr", imemAddr, 32'h0000_3018);
        redirectValid = 1'b1; redirectPc = 32'h0000_4003;
        tick();
        redirectValid = 1'b0;
        chk("rdAddrStable", imemAddr, 32'h0000_3018);
        tick();
        chk("rdAddrStable2", imemAddr, 32'h0000_3018);
        imemAck = 1'b1; imemRdata = 32'hDEAD_BEEF;
        tick();
        imemAck = 1'b0;
        chk("rdDropNoValid", {31'b0, instValid}, 32'd0);
        chk("rdReReq", {31'b0, imemReq}, 32'd1);
        chk("rdNewAddr", imemAddr, 32'h0000_4000);
        doFetch(32'h0000_4000, 0, 0, 32'h2108_0001);

        // Two redirects before the ack: the last one wins.
        waitReq();
        redirectValid = 1'b1; redirectPc = 32'h0000_4103;
        tick();
        redirectPc = 32'h0000_4200;
        tick();
        redirectValid = 1'b0;
        imemAck = 1'b1; imemRdata = 32'hBAD0_BAD0;
        tick();
        imemAck = 1'b0;
        chk("rd2NoValid", {31'b0, instValid}, 32'd0);
        chk("rd2Addr", imemAddr, 32'h0000_4200);
        doFetch(32'h0000_4200, 0, 0, 32'h3C01_1234);

        // Redirect in HOLD without ready: IR squashed.
        waitReq();
        chk("sqAddr", imemAddr, 32'h0000_4204);
        ackWord(32'h0000_4204, 32'h0123_4567);
        chk("sqValid", {31'b0, instValid}, 32'd1);
        redirectValid = 1'b1; redirectPc = 32'h0000_5000;
        tick();
        redirectValid = 1'b0;
        void'(sb.pop_front());
        chk("sqDropped", {31'b0, instValid}, 32'd0);
        chk("sqReq", {31'b0, imemReq}, 32'd1);
        chk("sqNewAddr", imemAddr, 32'h0000_5000);

        // Redirect in HOLD with ready: instruction consumed, then new target.
        ackWord(32'h0000_5000, 32'h2042_0005);
        redirectValid = 1'b1; redirectPc = 32'h0000_5000; instReady = 1'b1;
        deliver();
        tick();
        redirectValid = 1'b0; instReady = 1'b0;
        chk("rrValid", {31'b0, instValid}, 32'd0);
        chk("rrAddr", imemAddr, 32'h0000_5000);

        // PC wrap at the top of the address space.
        ackWord(32'h0000_5000, 32'h2042_0006);
        redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFF; instReady = 1'b1;
        deliver();
        tick();
        redirectValid = 1'b0; instReady = 1'b0;
        doFetch(32'hFFFF_FFFC, 0, 1, 32'h0000_000C);
        waitReq();
        chk("wrapAddr", imemAddr, 32'h0000_0000);

        // Reset mid-request, with an ack arriving while idle.
        tick();
        rst = 1'b1;
        tick();
        chk("mrReq", {31'b0, imemReq}, 32'd0);
        chk("mrAddr", imemAddr, 32'h0000_3000);
        chk("mrValid", {31'b0, instValid}, 32'd0);
        rst = 1'b0; imemAck = 1'b1; imemRdata = 32'hFFFF_0000;
        tick();
        imemAck = 1'b0;
        chk("mrIdleAckIgnored", {31'b0, instValid}, 32'd0);
        chk("mrReReq", {31'b0, imemReq}, 32'd1);
        doFetch(32'h0000_3000, 2, 0, 32'h8C22_0008);

`ifdef IFETCH_PERF_CNT_EN
        chk("fetchCount", fetchCount, expFetch);
        chk("stallCount", stallCount, expStall);
        chk("fetchCountAfterRst", fetchCount, 32'd1);
        chk("stallCountAfterRst", stallCount, 32'd2);
`endif
        chk("sbEmptyAtEnd", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Producer side of the opcode/funct interface: owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Latches each word into an instruction register and presents decoded fields (opcode, funct, rs, rt, rd, shamt, imm16, target26) to the control and ALU-control decoders with a valid/ready handshake.
- Accepts branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset; low 2 bits must be 0.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- imemReq  output  1  fetch request, held until imemAck
- imemAddr  output  32  fetch address, stable while imemReq=1
- imemAck  input  1  memory accepted request; imemRdata valid this cycle
- imemRdata  input  32  fetched word
- instValid  output  1  IR holds an instruction for the decoder
- instReady  input  1  decoder/pipeline consumes the instruction this cycle
- instWord  output  32  full instruction register
- opcode  output  6  instWord[31:26]
- rs  output  5  instWord[25:21]
- rt  output  5  instWord[20:16]
- rd  output  5  instWord[15:11]
- shamt  output  5  instWord[10:6]
- funct  output  6  instWord[5:0]
- imm16  output  16  instWord[15:0]
- target26  output  26  instWord[25:0]
- instPc  output  32  address of instruction in IR
- instPcPlus4  output  32  instPc+4, mod 2^32
- redirectValid  input  1  load new fetch PC
- redirectPc  input  32  new PC; bits [1:0] ignored (forced 00)

Behaviour:
- Reset (rst=1 at edge, any state):
  - state=IDLE, pc=RESET_PC, dropPending=0.
  - imemReq=0, instValid=0, instWord=0, instPc=0.
  - Reset mid-transaction abandons it; any later ack is ignored until the next REQ.
- Field outputs are pure slices of instWord.
- IDLE: next cycle goes to REQ. Redirect in IDLE loads pc=redirectPc.
- REQ:
  - imemReq=1, imemAddr=pc.
  - imemAck=0: stay in REQ; address held.
  - imemAck=1 and no drop condition: instWord<=imemRdata, instPc<=pc, pc<=pc+4, instValid<=1, go to HOLD.
- Drop condition in REQ: dropPending=1 or redirectValid=1 in the ack cycle. Then the response is discarded, dropPending<=0, and the FSM stays in REQ with the new pc (imemReq stays 1).
- Redirect in REQ without ack: pc is not changed (address must stay stable). Record dropPending=1 and pendingPc=redirectPc. On ack, pc<=pendingPc, discard the word, re-request.
- A later redirect while dropPending=1 overwrites pendingPc; the last redirect wins.
- HOLD:
  - instValid=1, imemReq=0; IR and fields are stable.
  - instReady=1: handshake completes; instValid<=0, go to REQ.
  - Redirect in HOLD with instReady=1: handshake completes and pc<=redirectPc.
  - Redirect in HOLD with instReady=0: IR is squashed (instValid<=0), pc<=redirectPc, go to REQ.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- Throughput: at most one instruction per 2 cycles (REQ with immediate ack, then HOLD with ready). Latency from req to instValid = ack cycle + 1.
- No combinational path from instReady to imemReq. imemReq depends only on state.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- When defined:
  - Adds output ports fetchCount[31:0] (increments on each instValid&&instReady) and stallCount[31:0] (increments each cycle with imemReq=1 && imemAck=0).
  - Both clear on rst and wrap at 2^32.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset then ack every request, instReady=1 -> imemAddr sequence 0x3000, 0x3004, 0x3008. instValid pulses every 2nd cycle; instPc matches; opcode/funct slices match the words loaded.
- Ack delayed 3 cycles on 0x3000 -> imemReq and imemAddr=0x3000 held 4 cycles, then instWord captured, instValid=1 next cycle.
- HOLD with instReady=0 for 5 cycles -> instValid, instWord, instPc stable. No imemReq until ready.
- redirectValid with redirectPc=0x4003 while in REQ waiting for ack -> ack'd word discarded, next imemAddr=0x4000, no instValid for the discarded word.
- Redirect 0x5000 in HOLD with instReady=0 -> instValid drops next cycle, next imemAddr=0x5000. Same with instReady=1 -> instruction consumed, next imemAddr=0x5000.
- redirectPc=0xFFFFFFFC, ack then ready -> instPcPlus4=0, next imemAddr=0x0. Assert rst mid-REQ -> imemReq=0, pc=0x3000 after reset. With IFETCH_PERF_CNT_EN: fetchCount and stallCount match scenario counts.
